// File: rtl/master_port_if.sv
// Serial system bus between one initiator (master_port) and one slave port.
//   read_en, write_en   : command lines, held for the whole transaction
//   master_valid        : request valid, held through serialisation
//   master_ready        : initiator is accepting read data
//   slave_ready         : slave can accept a request
//   slave_valid         : slave is driving a read data bit on rx_data
//   tx_addr/data/burst  : serial address, write data, burst descriptor (LSB first)
//   rx_data             : serial read data (LSB first)
interface master_port_if;
    logic read_en;
    logic write_en;
    logic master_valid;
    logic master_ready;
    logic slave_ready;
    logic slave_valid;
    logic tx_addr;
    logic tx_data;
    logic tx_burst;
    logic rx_data;

    modport master (
        output read_en, write_en, master_valid, master_ready,
        output tx_addr, tx_data, tx_burst,
        input  slave_ready, slave_valid, rx_data
    );

    modport slave (
        input  read_en, write_en, master_valid, master_ready,
        input  tx_addr, tx_data, tx_burst,
        output slave_ready, slave_valid, rx_data
    );
endinterface

// File: rtl/master_port.sv
// Bus-side initiator: accepts a parallel read/write request, performs the
// request/ready handshake, serialises address/write data/burst descriptor and
// deserialises returned read bytes.
//   clk, reset          : clock, asynchronous active-high reset
//   start, rw           : request strobe (accepted in IDLE only), 0=read 1=write
//   addr_in, wdata_in   : target address and write byte, sampled with start
//   burst_en, burst_len : burst read request and byte count (0 means 1)
//   busy, done          : transaction in progress, one-cycle completion pulse
//   rdata_out/valid     : last received byte and its one-cycle pulse
//   bus                 : serial bus lines (master side)
module master_port #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              burst_en,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    master_port_if.master     bus
);

    localparam int unsigned CNT_W = $clog2(LEN_W + 1);
    localparam int unsigned BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SEND,
        RECV,
        FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic [LEN_W:0]    desc_sr;
    logic              is_write;
    logic [LEN_W-1:0]  target;
    logic [CNT_W-1:0]  send_cnt;
    logic [3:0]        bit_cnt;
    logic [LEN_W-1:0]  byte_cnt;
    logic [DATA_W-2:0] rx_buf;

    logic [LEN_W-1:0]  eff_len_c;
    logic [LEN_W-1:0]  req_len_c;
    logic [LEN_W:0]    desc_c;

    // Descriptor length field carries the byte count the slave must return:
    // the burst length for burst reads, 1 for single reads, 0 for writes.
    always_comb begin
        eff_len_c = (burst_len == '0) ? LEN_W'(1) : burst_len;
        req_len_c = LEN_W'(1);
        if (rw) begin
            req_len_c = '0;
        end else if (burst_en) begin
            req_len_c = eff_len_c;
        end
        desc_c = {req_len_c, burst_en & ~rw};
    end

    // Serial lines are the LSBs of the shift registers; they drain to zero
    // once serialisation completes, so the lines idle low.
    assign bus.tx_addr  = addr_sr[0];
    assign bus.tx_data  = data_sr[0];
    assign bus.tx_burst = desc_sr[0];

    // Transaction sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            addr_sr          <= '0;
            data_sr          <= '0;
            desc_sr          <= '0;
            is_write         <= 1'b0;
            target           <= '0;
            send_cnt         <= '0;
            bit_cnt          <= '0;
            byte_cnt         <= '0;
            rx_buf           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            rdata_out        <= '0;
            rdata_valid      <= 1'b0;
            bus.read_en      <= 1'b0;
            bus.write_en     <= 1'b0;
            bus.master_valid <= 1'b0;
            bus.master_ready <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_sr          <= addr_in;
                        data_sr          <= wdata_in;
                        desc_sr          <= desc_c;
                        is_write         <= rw;
                        target           <= req_len_c;
                        busy             <= 1'b1;
                        bus.master_valid <= 1'b1;
                        bus.read_en      <= ~rw;
                        bus.write_en     <= rw;
                        state            <= REQ;
                    end
                end
                REQ: begin
                    // Bit 0 is on the lines during the handshake cycle.
                    if (bus.slave_ready) begin
                        addr_sr  <= addr_sr >> 1;
                        data_sr  <= data_sr >> 1;
                        desc_sr  <= desc_sr >> 1;
                        send_cnt <= CNT_W'(1);
                        state    <= SEND;
                    end
                end
                SEND: begin
                    addr_sr <= addr_sr >> 1;
                    data_sr <= data_sr >> 1;
                    desc_sr <= desc_sr >> 1;
                    if (send_cnt == CNT_W'(LEN_W)) begin
                        bus.master_valid <= 1'b0;
                        if (is_write) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            bus.master_ready <= 1'b1;
                            bit_cnt          <= '0;
                            byte_cnt         <= '0;
                            state            <= RECV;
                        end
                    end else begin
                        send_cnt <= send_cnt + CNT_W'(1);
                    end
                end
                RECV: begin
                    if (bus.slave_valid) begin
                        if (bit_cnt == 4'(DATA_W - 1)) begin
                            rdata_out   <= {bus.rx_data, rx_buf};
                            rdata_valid <= 1'b1;
                            bit_cnt     <= '0;
                            byte_cnt    <= byte_cnt + LEN_W'(1);
                            if (byte_cnt + LEN_W'(1) == target) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= FIN;
                            end
                        end else begin
                            rx_buf[bit_cnt[BIT_W-1:0]] <= bus.rx_data;
                            bit_cnt                    <= bit_cnt + 4'd1;
                        end
                    end
                end
                FIN: begin
                    done             <= 1'b0;
                    bus.read_en      <= 1'b0;
                    bus.write_en     <= 1'b0;
                    bus.master_ready <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
